proj_extender: RTL and testbench
================================

Name: proj_extender

Overview:
- Extension stage of the MinHash pipeline; sits between the sorter (which supplies the selected k-mer indices) and the external fragment memory.
- For each selected k-mer index, it computes a signed window start address so that a FRAG_LEN-bit fragment is centred on the k-mer.
- The environment returns that fragment combinationally on in_fragment.
- The block streams the fragment out in FRAG_PART-bit slices, one slice per clock, cycling through all indices continuously.

Parameters:
- KMER_LEN, 8, k-mer length in bits.
- FRAG_LEN, 32, fragment (window) length in bits; must be a multiple of FRAG_PART and >= KMER_LEN.
- INDICES_COUNT, 4, number of k-mer indices per sweep.
- INDICE_LEN, 5, width of each unsigned k-mer index.
- FRAG_PART, 8, output slice width.
- SIGNED_INDICE_LEN, INDICE_LEN+1, width of signed out_index.
- Derived: OFFSET = (FRAG_LEN-KMER_LEN)/2 (default 12); PARTS = FRAG_LEN/FRAG_PART (default 4).
- Constraint: OFFSET < 2^INDICE_LEN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_fragment  input  FRAG_LEN  fragment fetched at out_index; bit i = memory bit (out_index+i), zero-padded by the environment when out of range.
- in_kmer_indices  input  INDICES_COUNT x INDICE_LEN  packed array of k-mer start indices, element 0 at the LSBs.
- out_index  output  SIGNED_INDICE_LEN  signed window start address for the current index.
- out_gfm  output  FRAG_PART  registered fragment slice.

Behaviour:
- Reset and clocking: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- State registers: idx_cnt in 0..INDICES_COUNT-1 and part_cnt in 0..PARTS-1.
- Reset values: idx_cnt=0, part_cnt=0, out_gfm=0.
- out_index is combinational: $signed({1'b0, in_kmer_indices[idx_cnt]}) - OFFSET, computed at SIGNED_INDICE_LEN bits.
  - During reset it equals in_kmer_indices[0]-OFFSET.
  - Negative results are legal; the environment zero-pads them.
- Every rising edge with rst_n=1:
  - out_gfm <= in_fragment[part_cnt*FRAG_PART +: FRAG_PART]. Slice 0 is the LSBs, i.e. the start of the window.
  - part_cnt increments.
  - When part_cnt==PARTS-1, part_cnt wraps to 0 and idx_cnt increments.
  - idx_cnt wraps from INDICES_COUNT-1 to 0. A full sweep is INDICES_COUNT*PARTS cycles (16 at defaults), and sweeps repeat indefinitely with no gap.
- Latency: slice j of index i appears on out_gfm one clock after the cycle in which idx_cnt=i and part_cnt=j.
- in_kmer_indices and in_fragment are sampled live, not latched. A change to in_kmer_indices takes effect on out_index immediately and on out_gfm at the next edge. The upstream stage holds the indices stable for a sweep.
- No handshake: the block free-runs whenever out of reset.
- Reset asserted mid-sweep:
  - out_gfm goes to 0 and both counters go to 0 immediately (asynchronous).
  - After release, the sweep restarts at index 0, slice 0.
- Index 0 with OFFSET>0 gives a negative out_index (two's complement). The maximum index gives 2^INDICE_LEN-1-OFFSET. No saturation.
- No X propagation from counters; counters never exceed their ranges.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 with in_kmer_indices[0]=20.
  - Required response: out_gfm=0x00 and out_index=8 (20-12). Release; the first posedge samples slice 0.
- Slice order:
  - Stimulus: in_fragment=0xDEADBEEF held constant, default parameters.
  - Required response: out_gfm after successive edges = 0xEF, 0xBE, 0xAD, 0xDE, then 0xEF again for the next index.
- Index stepping and wrap:
  - Stimulus: indices {3,31,12,20} (element 0 = 20, element 3 = 3).
  - Required response: out_index = 8 for 4 cycles, then 0, then 19, then -9 (6'h37), then back to 8 at cycle 16.
- Negative/padded window:
  - Stimulus: index 0; environment supplies zero-padded fragment 0x00000ABC for out_index=-12.
  - Required response: out_gfm sequence 0xBC, 0x0A, 0x00, 0x00.
- Mid-sweep reset:
  - Stimulus: assert rst_n=0 asynchronously at idx_cnt=2, part_cnt=1.
  - Required response: out_gfm=0 before the next edge. After release, out_index=kmer[0]-12 and slice 0 is output first.
- Randomized sweeps:
  - Stimulus: 10 sweeps with random indices 0..31 and a 32-bit memory model with zero padding.
  - Required response: every out_gfm equals the reference slice of mem window [out_index, out_index+31].

Source files
------------

// File: rtl/proj_extender.sv
// MinHash extension stage: turns each selected k-mer index into a signed window
// start address and streams the returned fragment out one slice per clock.
module proj_extender #(
    parameter int KMER_LEN          = 8,
    parameter int FRAG_LEN          = 32,
    parameter int INDICES_COUNT     = 4,
    parameter int INDICE_LEN        = 5,
    parameter int FRAG_PART         = 8,
    parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [FRAG_LEN-1:0]                      in_fragment,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_kmer_indices,
    output logic signed [SIGNED_INDICE_LEN-1:0]      out_index,
    output logic [FRAG_PART-1:0]                     out_gfm
);

    localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;
    localparam int PARTS  = FRAG_LEN / FRAG_PART;
    localparam int IDX_W  = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;

    localparam logic [IDX_W-1:0]             IDX_LAST  = IDX_W'(INDICES_COUNT - 1);
    localparam logic [PART_W-1:0]            PART_LAST = PART_W'(PARTS - 1);
    localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_V  = SIGNED_INDICE_LEN'(OFFSET);

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [PART_W-1:0]               part_q, part_d;
    logic [FRAG_PART-1:0]            gfm_q, gfm_d;
    logic [PARTS-1:0][FRAG_PART-1:0] frag_parts;
    logic [INDICE_LEN-1:0]           cur_kmer;
    logic [SIGNED_INDICE_LEN-1:0]    kmer_ext;

    // Slice 0 sits at the LSBs, i.e. the start of the window.
    assign frag_parts = in_fragment;
    assign cur_kmer   = in_kmer_indices[idx_q];
    assign kmer_ext   = SIGNED_INDICE_LEN'(cur_kmer);

    // Wraps negative for small indices; the memory side zero-pads those windows.
    assign out_index  = $signed(kmer_ext - OFFSET_V);
    assign out_gfm    = gfm_q;

    always_comb begin
        gfm_d  = frag_parts[part_q];
        part_d = part_q;
        idx_d  = idx_q;
        if (part_q == PART_LAST) begin
            part_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            part_d = part_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            part_q <= '0;
            gfm_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            part_q <= part_d;
            gfm_q  <= gfm_d;
        end
    end

endmodule

// File: tb/tb_proj_extender.sv
// Bench for proj_extender: directed sweeps with literal expectations plus a
// cycle-count based reference model compared on every falling edge.
module tb_proj_extender;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      in_fragment;
    logic [3:0][4:0]  kmer;
    logic [5:0]       out_index;
    logic [7:0]       out_gfm;

    logic             use_mem = 1'b0;
    logic [31:0]      frag_drv = 32'h0;
    logic [31:0]      mem = 32'h0;

    int               n_checks = 0;
    int               n_fail = 0;
    int               n_cyc = 0;
    logic [7:0]       exp_q[$];
    logic [7:0]       model_gfm = 8'h00;
    logic [5:0]       exp_idx;

    logic [7:0]       beef_sl [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [5:0]       idx_tab [4] = '{6'd8, 6'd0, 6'd19, 6'h37};
    logic [7:0]       abc_sl  [4] = '{8'hBC, 8'h0A, 8'h00, 8'h00};
    logic [7:0]       mem_sl  [4] = '{8'h56, 8'h34, 8'h12, 8'h00};

    proj_extender dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_fragment     (in_fragment),
        .in_kmer_indices (kmer),
        .out_index       (out_index),
        .out_gfm         (out_gfm)
    );

    always #5 clk = ~clk;

    // Memory environment: window starting at 'start', zero outside bits 0..31.
    function automatic logic [31:0] env_frag(input int start, input logic mem_mode,
                                             input logic [31:0] fixed, input logic [31:0] m);
        logic [31:0] f;
        int a;
        if (!mem_mode) return fixed;
        f = '0;
        for (int b = 0; b < 32; b++) begin
            a = start + b;
            if (a >= 0 && a < 32) f[b] = m[a];
        end
        return f;
    endfunction

    always_comb in_fragment = env_frag(int'($signed(out_index)), use_mem, frag_drv, mem);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycle n after reset handles index (n/4)%4, slice n%4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cyc = 0;
            exp_q.delete();
            model_gfm = 8'h00;
        end else begin
            int start;
            logic [31:0] f;
            start = int'(kmer[(n_cyc / 4) % 4]) - 12;
            f = env_frag(start, use_mem, frag_drv, mem);
            exp_q.push_back(f[(n_cyc % 4) * 8 +: 8]);
            n_cyc++;
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) model_gfm = exp_q.pop_front();
        check("gfm_model", {24'h0, out_gfm}, {24'h0, model_gfm});
        exp_idx = 6'(int'(kmer[(n_cyc / 4) % 4]) - 12);
        check("index_model", {26'h0, out_index}, {26'h0, exp_idx});
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic assert_rst;
        step();
        rst_n = 1'b0;
    endtask

    task automatic release_rst;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        kmer = {5'd3, 5'd31, 5'd12, 5'd20};
        frag_drv = 32'hDEADBEEF;
        #23;
        check("reset_gfm", {24'h0, out_gfm}, 32'h0);
        check("reset_index", {26'h0, out_index}, 32'd8);
        release_rst();

        // Slice order and index stepping over one full sweep plus wrap.
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            check("slice_order", {24'h0, out_gfm}, (k == 0) ? 32'h0 : {24'h0, beef_sl[(k - 1) % 4]});
            check("index_step", {26'h0, out_index}, {26'h0, idx_tab[(k / 4) % 4]});
        end

        // Negative window at index 0, fragment supplied zero-padded.
        assert_rst();
        kmer = '0;
        frag_drv = 32'h00000ABC;
        release_rst();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("neg_window_gfm", {24'h0, out_gfm}, {24'h0, abc_sl[k]});
            check("neg_window_index", {26'h0, out_index}, 32'h34);
        end

        // Reset asserted at idx_cnt=2, part_cnt=1.
        assert_rst();
        kmer = {5'd3, 5'd31, 5'd12, 5'd20};
        frag_drv = 32'hDEADBEEF;
        release_rst();
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_gfm", {24'h0, out_gfm}, 32'hEF);
        check("pre_reset_index", {26'h0, out_index}, 32'd19);
        rst_n = 1'b0;
        #1;
        check("async_reset_gfm", {24'h0, out_gfm}, 32'h0);
        check("async_reset_index", {26'h0, out_index}, 32'd8);
        release_rst();
        @(negedge clk);
        check("restart_pre_gfm", {24'h0, out_gfm}, 32'h0);
        @(negedge clk);
        check("restart_slice0", {24'h0, out_gfm}, 32'hEF);
        check("restart_index", {26'h0, out_index}, 32'd8);

        // Memory-backed window pinned by hand: start 8 over 0x12345678.
        assert_rst();
        use_mem = 1'b1;
        mem = 32'h12345678;
        kmer = {4{5'd20}};
        release_rst();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mem_window_gfm", {24'h0, out_gfm}, {24'h0, mem_sl[k]});
        end

        // Random sweeps, indices held stable for each sweep.
        assert_rst();
        release_rst();
        for (int s = 0; s < 10; s++) begin
            for (int e = 0; e < 4; e++) kmer[e] = 5'($urandom_range(0, 31));
            mem = $urandom;
            repeat (16) @(posedge clk);
            #2;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
